fre_lst: RTL and testbench
==========================

FRE_LST -- requirements
Module: fre_lst

Interface
REQ-001 Parameter NUM_PREG, default 64: physical register count.
REQ-002 Parameter ISQ_DEPTH, default 64: number of release entries per cycle, one per tpu line.
REQ-003 Parameter ALC_PORT, default 4: allocation slots per cycle.
REQ-004 Parameter NUM_ARCH, default 16: physical registers 0..15, mapped to logical 0..15 at reset.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 fre_preg_in_flat  in  7*ISQ_DEPTH  per-entry freed preg, entry i at [7i+6:7i]; bit 6 = valid, [5:0] = preg index.
REQ-008 fre_en  in  ISQ_DEPTH  per-entry release strobe; entry i releases only when fre_en[i] and its valid bit are both 1.
REQ-009 alc_req  in  ALC_PORT  per-slot allocation request for a new pdest.
REQ-010 alc_gnt  out  ALC_PORT  per-slot grant.
REQ-011 alc_preg_flat  out  6*ALC_PORT  granted preg index, slot k at [6k+5:6k].
REQ-012 alc_stl  out  1  request not satisfiable this cycle; rename must stall.
REQ-013 fre_cnt  out  7  number of free pregs, 0..64.
REQ-014 dbl_fre_err  out  1  sticky error flag: a free preg was released again.

Function
REQ-015 State SHALL be a NUM_PREG-bit free bitmap fre_map; bit p = 1 means preg p is free.
REQ-016 Grants SHALL be combinational from the registered fre_map; zero-cycle latency from alc_req to alc_gnt and alc_preg_flat.
REQ-017 Slot k SHALL receive the (r+1)-th lowest free index, where r = number of requesting slots below k; requesting slots are packed regardless of gaps in alc_req.
REQ-018 Allocation SHALL be all-or-nothing: if popcount(alc_req) > fre_cnt, then alc_stl=1, alc_gnt=0 and fre_map is not cleared for any slot.
REQ-019 When alc_req=0: alc_stl=0 and alc_gnt=0.
REQ-020 alc_preg_flat for a non-granted slot SHALL be 0.
REQ-021 Next fre_map = (fre_map & ~granted_mask) | release_mask, where release_mask ORs all enabled valid entries.
REQ-022 No same-cycle bypass: a preg released in cycle t SHALL be allocatable in cycle t+1 at the earliest.
REQ-023 Duplicate releases of the same preg in one cycle SHALL set its bit once and are not an error.
REQ-024 dbl_fre_err SHALL set at the next edge when a release targets a preg whose fre_map bit is already 1.
REQ-025 dbl_fre_err SHALL then hold until rst; fre_map is still updated by REQ-021.
REQ-026 fre_cnt SHALL be the registered popcount of fre_map, updated in the same edge as fre_map.
REQ-027 fre_cnt SHALL never exceed 64; 7-bit width is sufficient.

Reset
REQ-028 On rst at posedge: fre_map = ones in bits 16..63 and zeros in 0..15; fre_cnt=48; dbl_fre_err=0.
REQ-029 rst SHALL take priority over any same-cycle release or grant; grants issued in that cycle are discarded.
REQ-030 With fre_map at reset value, the combinational outputs SHALL be alc_gnt=0 and alc_stl=0 whenever alc_req=0.

Structure
REQ-031 Shared package (fre_pkg) SHALL hold NUM_PREG, PREG_IDX_BITS=6, ALC_PORT, NUM_ARCH and the reset free mask.
REQ-032 The package constants SHALL be shared with tpu and the rename stage.
REQ-033 One sub-module fre_pri_enc SHALL provide a 64-bit find-first-set with index and found flag.
REQ-034 fre_pri_enc SHALL be instantiated ALC_PORT times in a chain, each instance seeing the map with prior picks masked out.
REQ-035 Release decode and popcount SHALL be inline generate logic.

Verification
REQ-036 Reset, then alc_req=4'b1111 -> alc_gnt=1111, pregs 16,17,18,19; next cycle fre_cnt=44.
REQ-037 alc_req=4'b1010 from reset state -> slot1=16, slot3=17, slots0/2 gnt=0 and preg=0; next fre_cnt=46.
REQ-038 Drain to fre_cnt=2, then alc_req=4'b0111 -> alc_stl=1, alc_gnt=0, fre_cnt stays 2 next cycle.
REQ-039 Allocated preg 20 released via entry 5 (fre_en[5]=1, valid, idx 20) in cycle t:
- alc_req=0001 in t still skips 20;
- alc_req=0001 in t+1 returns 20 if lowest free.
REQ-040 Release preg 40 while free -> dbl_fre_err=1 next cycle, held until rst.
REQ-041 Same preg released from two entries plus valid=0 entries with fre_en=1 -> count +1 only, no error.
REQ-042 Assert rst with alc_req=1111 and releases active -> next cycle fre_cnt=48, map reset value, dbl_fre_err=0.

Source files
------------

// File: rtl/fre_pkg.sv
// Free-list shared constants for the rename stage, tpu and fre_lst.
// Covers the physical register count, preg index width, allocation slots,
// architectural register count, release entry layout and reset free mask.
package fre_pkg;
    localparam int NUM_PREG      = 64;
    localparam int PREG_IDX_BITS = 6;
    localparam int ALC_PORT      = 4;
    localparam int NUM_ARCH      = 16;
    localparam int ISQ_DEPTH     = 64;

    // Each release entry is {valid, preg index}.
    localparam int REL_W         = PREG_IDX_BITS + 1;
    // Wide enough to hold 0..NUM_PREG.
    localparam int CNT_BITS      = 7;

    // Pregs 0..NUM_ARCH-1 hold the architectural mapping out of reset.
    // All other pregs start free.
    localparam logic [NUM_PREG-1:0] RST_FRE_MASK =
        {{(NUM_PREG-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
endpackage

// File: rtl/fre_pri_enc.sv
// Find-first-set over the free map. The lowest set bit wins.
// Ports:
//   vec   in  W     candidate bitmap
//   idx   out IDXW  index of the lowest set bit (0 when none is set)
//   found out 1     at least one bit of vec is set
module fre_pri_enc
    import fre_pkg::*;
#(
    parameter int W    = NUM_PREG,
    parameter int IDXW = PREG_IDX_BITS
) (
    input  logic [W-1:0]    vec,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDXW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fre_lst.sv
// Physical register free list. The free map is one bit per preg, and a set
// bit means the preg is free. Up to ALC_PORT pregs are granted
// combinationally per cycle. Up to ISQ_DEPTH pregs are released per cycle.
// Ports:
//   clk              in  1              clock, all state on posedge
//   rst              in  1              synchronous active-high reset
//   fre_preg_in_flat in  7*ISQ_DEPTH    release entries {valid, idx}
//   fre_en           in  ISQ_DEPTH      release strobe per entry
//   alc_req          in  ALC_PORT       allocation request per slot
//   alc_gnt          out ALC_PORT       grant per slot
//   alc_preg_flat    out 6*ALC_PORT     granted preg per slot (0 if not granted)
//   alc_stl          out 1              request cannot be met this cycle
//   fre_cnt          out 7              registered count of free pregs
//   dbl_fre_err      out 1              sticky: an already-free preg was released
module fre_lst #(
    parameter int NUM_PREG  = fre_pkg::NUM_PREG,
    parameter int ISQ_DEPTH = fre_pkg::ISQ_DEPTH,
    parameter int ALC_PORT  = fre_pkg::ALC_PORT,
    parameter int NUM_ARCH  = fre_pkg::NUM_ARCH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [fre_pkg::REL_W*ISQ_DEPTH-1:0]   fre_preg_in_flat,
    input  logic [ISQ_DEPTH-1:0]                  fre_en,
    input  logic [ALC_PORT-1:0]                   alc_req,
    output logic [ALC_PORT-1:0]                   alc_gnt,
    output logic [fre_pkg::PREG_IDX_BITS*ALC_PORT-1:0] alc_preg_flat,
    output logic                                  alc_stl,
    output logic [fre_pkg::CNT_BITS-1:0]          fre_cnt,
    output logic                                  dbl_fre_err
);
    import fre_pkg::*;

    logic [NUM_PREG-1:0] fre_map;
    logic [NUM_PREG-1:0] fre_map_nxt;
    logic [NUM_PREG-1:0] pick_mask;
    logic [NUM_PREG-1:0] granted_mask;
    logic [NUM_PREG-1:0] release_mask;
    logic [ALC_PORT-1:0] pick_ok;
    logic                grant_all;
    logic                dbl_hit;
    logic [CNT_BITS-1:0] cnt_nxt;

    // Allocation chain. Each slot searches the map with the picks of the
    // requesting slots below it removed. Non-requesting slots take nothing,
    // so requesters pack onto consecutive free indices.
    for (genvar k = 0; k < ALC_PORT; k++) begin : g_slot
        logic [NUM_PREG-1:0]      taken;
        logic [NUM_PREG-1:0]      vin;
        logic [NUM_PREG-1:0]      oh;
        logic [PREG_IDX_BITS-1:0] idx;
        logic                     found;

        if (k == 0) begin : g_first
            assign taken = '0;
        end else begin : g_rest
            assign taken = g_slot[k-1].taken | g_slot[k-1].oh;
        end

        assign vin = fre_map & ~taken;

        fre_pri_enc #(
            .W    (NUM_PREG),
            .IDXW (PREG_IDX_BITS)
        ) u_enc (
            .vec   (vin),
            .idx   (idx),
            .found (found)
        );

        assign oh         = (alc_req[k] && found) ? (NUM_PREG'(1) << idx) : '0;
        assign pick_ok[k] = found | ~alc_req[k];
        assign alc_gnt[k] = grant_all & alc_req[k];
        assign alc_preg_flat[PREG_IDX_BITS*k +: PREG_IDX_BITS] =
            alc_gnt[k] ? idx : '0;
    end

    assign pick_mask = g_slot[ALC_PORT-1].taken | g_slot[ALC_PORT-1].oh;

    // All-or-nothing. A single slot that runs out of free pregs cancels
    // every grant in the cycle.
    assign grant_all    = &pick_ok;
    assign alc_stl      = (|alc_req) & ~grant_all;
    assign granted_mask = grant_all ? pick_mask : '0;

    // Release decode. Each entry turns into a one-hot mask, and the masks
    // are ORed down the chain. Duplicate entries collapse into one bit.
    for (genvar i = 0; i < ISQ_DEPTH; i++) begin : g_rel
        logic [NUM_PREG-1:0] oh;
        logic [NUM_PREG-1:0] acc;

        assign oh = (fre_en[i] && fre_preg_in_flat[REL_W*i + PREG_IDX_BITS])
                  ? (NUM_PREG'(1) << fre_preg_in_flat[REL_W*i +: PREG_IDX_BITS])
                  : '0;

        if (i == 0) begin : g_first
            assign acc = oh;
        end else begin : g_rest
            assign acc = g_rel[i-1].acc | oh;
        end
    end

    assign release_mask = g_rel[ISQ_DEPTH-1].acc;
    assign dbl_hit      = |(release_mask & fre_map);

    // A release only touches the map at the next edge, so it is never
    // visible to the grant logic in the same cycle.
    assign fre_map_nxt  = (fre_map & ~granted_mask) | release_mask;

    always_comb begin
        cnt_nxt = '0;
        for (int p = 0; p < NUM_PREG; p++) begin
            cnt_nxt = cnt_nxt + CNT_BITS'(fre_map_nxt[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fre_map     <= RST_FRE_MASK;
            fre_cnt     <= CNT_BITS'(NUM_PREG - NUM_ARCH);
            dbl_fre_err <= 1'b0;
        end else begin
            fre_map     <= fre_map_nxt;
            fre_cnt     <= cnt_nxt;
            dbl_fre_err <= dbl_fre_err | dbl_hit;
        end
    end

endmodule

// File: tb/tb_fre_lst.sv
module tb_fre_lst;

    logic         clk = 1'b0;
    logic         rst;
    logic [447:0] fre_preg_in_flat;
    logic [63:0]  fre_en;
    logic [3:0]   alc_req;
    logic [3:0]   alc_gnt;
    logic [23:0]  alc_preg_flat;
    logic         alc_stl;
    logic [6:0]   fre_cnt;
    logic         dbl_fre_err;

    int errors = 0;
    int checks = 0;

    // Reference state: a plain free set plus the sticky error flag.
    bit [63:0] m;
    bit        merr;

    localparam bit [63:0] RST_MAP = 64'hFFFF_FFFF_FFFF_0000;

    fre_lst dut (
        .clk              (clk),
        .rst              (rst),
        .fre_preg_in_flat (fre_preg_in_flat),
        .fre_en           (fre_en),
        .alc_req          (alc_req),
        .alc_gnt          (alc_gnt),
        .alc_preg_flat    (alc_preg_flat),
        .alc_stl          (alc_stl),
        .fre_cnt          (fre_cnt),
        .dbl_fre_err      (dbl_fre_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_rel();
        fre_preg_in_flat = '0;
        fre_en           = '0;
    endtask

    task automatic set_rel(input int i, input int idx, input bit v, input bit en);
        fre_preg_in_flat[7*i +: 7] = {v, 6'(idx)};
        fre_en[i]                  = en;
    endtask

    // Requesters, taken in slot order, receive consecutive entries of the
    // ascending free list. The whole request is refused if it is larger
    // than the free list.
    task automatic model_alloc(output logic [3:0] g, output logic [23:0] pf,
                               output logic s, output logic [63:0] gm);
        int fl[$];
        int r;
        g = '0; pf = '0; s = 1'b0; gm = '0;
        for (int p = 0; p < 64; p++) if (m[p]) fl.push_back(p);
        if ($countones(alc_req) > fl.size()) begin
            s = 1'b1;
        end else begin
            r = 0;
            for (int k = 0; k < 4; k++) begin
                if (alc_req[k]) begin
                    g[k]         = 1'b1;
                    pf[6*k +: 6] = 6'(fl[r]);
                    gm[fl[r]]    = 1'b1;
                    r++;
                end
            end
        end
    endtask

    // One clock: compare every output against the model, then advance the
    // model with the inputs that the DUT samples at this edge.
    task automatic do_cycle();
        logic [3:0]  eg;
        logic [23:0] epf;
        logic        es;
        logic [63:0] egm;
        bit [63:0]   rel;
        bit          dbl;
        int          p;
        #1;
        model_alloc(eg, epf, es, egm);
        chk("alc_gnt", 64'(alc_gnt), 64'(eg));
        chk("alc_preg_flat", 64'(alc_preg_flat), 64'(epf));
        chk("alc_stl", 64'(alc_stl), 64'(es));
        chk("fre_cnt", 64'(fre_cnt), 64'($countones(m)));
        chk("dbl_fre_err", 64'(dbl_fre_err), 64'(merr));
        @(posedge clk);
        if (rst) begin
            m    = RST_MAP;
            merr = 1'b0;
        end else begin
            rel = '0;
            dbl = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (fre_en[i] && fre_preg_in_flat[7*i+6]) begin
                    p = int'(fre_preg_in_flat[7*i +: 6]);
                    if (m[p]) dbl = 1'b1;
                    rel[p] = 1'b1;
                end
            end
            m    = (m & ~egm) | rel;
            merr = merr | dbl;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alc_req = '0;
        clr_rel();
        do_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int pick;
        int n;
        rst = 1'b1;
        alc_req = '0;
        clr_rel();
        // The first edge brings the DUT out of X, so no comparison is made yet.
        @(posedge clk);
        m = RST_MAP;
        merr = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset state with no requests.
        #1;
        chk("rst_cnt", 64'(fre_cnt), 64'd48);
        chk("rst_err", 64'(dbl_fre_err), 64'd0);
        chk("rst_gnt", 64'(alc_gnt), 64'd0);
        chk("rst_stl", 64'(alc_stl), 64'd0);
        do_cycle();

        // Four requests out of reset.
        alc_req = 4'b1111;
        #1;
        chk("all4_gnt", 64'(alc_gnt), 64'hF);
        chk("all4_preg", 64'(alc_preg_flat), 64'({6'd19, 6'd18, 6'd17, 6'd16}));
        do_cycle();
        alc_req = '0;
        #1;
        chk("all4_cnt", 64'(fre_cnt), 64'd44);
        do_cycle();

        // Sparse requesters pack onto the lowest free pregs.
        do_reset();
        alc_req = 4'b1010;
        #1;
        chk("gap_gnt", 64'(alc_gnt), 64'hA);
        chk("gap_preg", 64'(alc_preg_flat), 64'({6'd17, 6'd0, 6'd16, 6'd0}));
        do_cycle();
        alc_req = '0;
        #1;
        chk("gap_cnt", 64'(fre_cnt), 64'd46);
        do_cycle();

        // Drain to two free pregs, then request three.
        do_reset();
        alc_req = 4'b1111;
        repeat (11) do_cycle();
        alc_req = 4'b0011;
        do_cycle();
        alc_req = 4'b0111;
        #1;
        chk("stall_stl", 64'(alc_stl), 64'd1);
        chk("stall_gnt", 64'(alc_gnt), 64'd0);
        do_cycle();
        alc_req = '0;
        #1;
        chk("stall_cnt", 64'(fre_cnt), 64'd2);
        do_cycle();

        // A release is not visible to the grant logic until the next cycle.
        do_reset();
        alc_req = 4'b1111;
        do_cycle();
        alc_req = 4'b0001;
        do_cycle();
        set_rel(5, 20, 1'b1, 1'b1);
        #1;
        chk("bypass_t", 64'(alc_preg_flat[5:0]), 64'd21);
        do_cycle();
        clr_rel();
        #1;
        chk("bypass_t1", 64'(alc_preg_flat[5:0]), 64'd20);
        do_cycle();
        alc_req = '0;

        // Duplicate release in one cycle, plus strobed entries that are not valid.
        set_rel(3, 16, 1'b1, 1'b1);
        set_rel(9, 16, 1'b1, 1'b1);
        set_rel(10, 17, 1'b0, 1'b1);
        set_rel(11, 17, 1'b0, 1'b1);
        do_cycle();
        clr_rel();
        #1;
        chk("dup_cnt", 64'(fre_cnt), 64'd43);
        chk("dup_err", 64'(dbl_fre_err), 64'd0);
        do_cycle();

        // Releasing a preg that is already free raises the sticky error.
        set_rel(0, 40, 1'b1, 1'b1);
        do_cycle();
        clr_rel();
        #1;
        chk("dbl_set", 64'(dbl_fre_err), 64'd1);
        repeat (3) do_cycle();
        #1;
        chk("dbl_hold", 64'(dbl_fre_err), 64'd1);
        do_cycle();

        // Randomized traffic. Releases mostly target allocated pregs.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            alc_req = 4'($urandom);
            if (((c / 100) % 2) == 0 && ($urandom_range(0, 1) == 0)) alc_req = 4'b1111;
            clr_rel();
            n = (((c / 100) % 2) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 6);
            for (int j = 0; j < n; j++) begin
                pick = $urandom_range(0, 63);
                for (int t = 0; t < 8 && m[pick]; t++) pick = $urandom_range(0, 63);
                if ($urandom_range(0, 63) == 0) pick = $urandom_range(0, 63);
                set_rel($urandom_range(0, 63), pick,
                        $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
            end
            rst = ($urandom_range(0, 199) == 0);
            do_cycle();
            rst = 1'b0;
        end

        // Reset wins over same-cycle grants and releases.
        alc_req = 4'b1111;
        clr_rel();
        set_rel(0, 5, 1'b1, 1'b1);
        set_rel(7, 30, 1'b1, 1'b1);
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        clr_rel();
        #1;
        chk("rstpri_cnt", 64'(fre_cnt), 64'd48);
        chk("rstpri_err", 64'(dbl_fre_err), 64'd0);
        chk("rstpri_map", 64'(alc_preg_flat), 64'({6'd19, 6'd18, 6'd17, 6'd16}));
        do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
